// File: rtl/ysyx_22041752_mem_stage.sv
// Memory-access pipeline stage: waits on load data, aligns/extends it and
// hands the result to write-back while exporting a decode forwarding bus.
`ifndef YSYX_22041752_MYCPU_VH
`define YSYX_22041752_MYCPU_VH
`define PC_WD             64
`define ES_TO_MS_BUS_WD   (75 + `PC_WD)
`define MS_TO_WS_BUS_WD   (70 + `PC_WD)
`define MS_FORWARD_BUS_WD 71
`endif

module ysyx_22041752_mem_stage (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ws_allowin,
  output logic                          ms_allowin,
  input  logic                          es_to_ms_valid,
  input  logic [`ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  input  logic [63:0]                   data_sram_rdata,
  input  logic                          data_sram_rvalid,
  output logic                          ms_to_ws_valid,
  output logic [`MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
  output logic [`MS_FORWARD_BUS_WD-1:0] ms_forward_bus
);

  localparam int AluLo   = `PC_WD;
  localparam int RdLo    = `PC_WD + 64;
  localparam int WeBit   = `PC_WD + 69;
  localparam int ReBit   = `PC_WD + 70;
  localparam int SzLo    = `PC_WD + 71;
  localparam int ZextBit = `PC_WD + 73;
  localparam int SextBit = `PC_WD + 74;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic                          ms_valid_q;
  logic [`ES_TO_MS_BUS_WD-1:0]   bus_q;
  logic [63:0]                   ld_buf_q, ld_buf_d;

  logic [`PC_WD-1:0] pc_s;
  logic [63:0]       alu_result_s;
  logic [4:0]        rd_s;
  logic              rf_we_s;
  logic              mem_re_s;
  logic [1:0]        mem_bytes_s;
  logic              res_zext_s;
  logic              res_sext_s;
  logic              unused_res_sext_s;
  logic              load_s;
  logic              ms_ready_go_s;
  logic [63:0]       raw_s;
  logic [63:0]       final_result_s;

  // Shift the doubleword down to the addressed byte, then size and extend it.
  function automatic logic [63:0] align_load(input logic [63:0] raw,
                                             input logic [2:0]  off,
                                             input logic [1:0]  bytes,
                                             input logic        zext);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    case (bytes)
      2'b00:   align_load = zext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   align_load = zext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   align_load = zext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: align_load = sh;
    endcase
  endfunction

  assign pc_s         = bus_q[`PC_WD-1:0];
  assign alu_result_s = bus_q[AluLo+63:AluLo];
  assign rd_s         = bus_q[RdLo+4:RdLo];
  assign rf_we_s      = bus_q[WeBit];
  assign mem_re_s     = bus_q[ReBit];
  assign mem_bytes_s  = bus_q[SzLo+1:SzLo];
  assign res_zext_s   = bus_q[ZextBit];
  // Sign extension is the default whenever zext is clear, so sext is redundant.
  assign res_sext_s        = bus_q[SextBit];
  assign unused_res_sext_s = res_sext_s;

  assign load_s = ms_valid_q && mem_re_s;

  // Handshake and result selection.
  always_comb begin
    ms_ready_go_s = 1'b1;
    if (!mem_re_s) begin
      ms_ready_go_s = 1'b1;
    end else if (state_q == ST_HOLD) begin
      ms_ready_go_s = 1'b1;
    end else begin
      ms_ready_go_s = data_sram_rvalid;
    end
    raw_s = (state_q == ST_HOLD) ? ld_buf_q : data_sram_rdata;
    if (mem_re_s) begin
      final_result_s = align_load(raw_s, alu_result_s[2:0], mem_bytes_s, res_zext_s);
    end else begin
      final_result_s = alu_result_s;
    end
  end

  assign ms_allowin     = !ms_valid_q || (ms_ready_go_s && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go_s;
  assign ms_to_ws_bus   = {rf_we_s, rd_s, final_result_s, pc_s};
  assign ms_forward_bus = {load_s && !ms_ready_go_s, ms_valid_q && rf_we_s,
                           final_result_s, rd_s};

  // Load FSM: track an outstanding response and park data during a WB stall.
  always_comb begin
    state_d  = state_q;
    ld_buf_d = ld_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (load_s && !data_sram_rvalid) begin
          state_d = ST_WAIT;
        end else if (load_s && !ws_allowin) begin
          state_d  = ST_HOLD;
          ld_buf_d = data_sram_rdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!load_s) begin
          state_d = ST_IDLE;
        end else if (data_sram_rvalid && ws_allowin) begin
          state_d = ST_IDLE;
        end else if (data_sram_rvalid) begin
          state_d  = ST_HOLD;
          ld_buf_d = data_sram_rdata;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (ws_allowin) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ms_valid_q <= 1'b0;
      ld_buf_q   <= 64'd0;
      bus_q      <= '0;
    end else begin
      state_q  <= state_d;
      ld_buf_q <= ld_buf_d;
      if (ms_allowin) begin
        ms_valid_q <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        bus_q <= es_to_ms_bus;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_mem_stage.sv
// Directed bench for the memory stage: a transaction-level model predicts every
// cycle's outputs, and literal expectations pin the model on key cases.
module tb_ysyx_22041752_mem_stage;

  localparam int ESW = 139;
  localparam int WSW = 134;
  localparam int FWW = 71;

  logic            clk = 1'b0;
  logic            reset;
  logic            ws_allowin;
  logic            ms_allowin;
  logic            es_to_ms_valid;
  logic [ESW-1:0]  es_to_ms_bus;
  logic [63:0]     data_sram_rdata;
  logic            data_sram_rvalid;
  logic            ms_to_ws_valid;
  logic [WSW-1:0]  ms_to_ws_bus;
  logic [FWW-1:0]  ms_forward_bus;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  ysyx_22041752_mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_forward_bus   (ms_forward_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [ESW-1:0] mk(input logic zext, input logic [1:0] sz, input logic re,
                                        input logic we, input logic [4:0] rd,
                                        input logic [63:0] alu, input logic [63:0] pc);
    return {~zext & re, zext, sz, re, we, rd, alu, pc};
  endfunction

  // Model: load extension by masking and sign filling of the shifted value.
  function automatic logic [63:0] ext_ld(input logic [63:0] raw, input logic [2:0] off,
                                         input logic [1:0] sz, input logic zext);
    int          nbits;
    logic [63:0] v;
    logic [63:0] mask;
    nbits = 8 << sz;
    v = raw >> (int'(off) * 8);
    if (nbits == 64) return v;
    mask = (64'd1 << nbits) - 64'd1;
    v = v & mask;
    if (!zext && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  // Model state: held instruction and, for loads, whether its data is already in hand.
  logic           m_valid;
  logic [ESW-1:0] m_bus;
  logic           m_have;
  logic [63:0]    m_data;

  logic        m_re, m_we, m_zext;
  logic [1:0]  m_sz;
  logic [4:0]  m_rd;
  logic [63:0] m_alu, m_pc;
  assign m_pc   = m_bus[63:0];
  assign m_alu  = m_bus[127:64];
  assign m_rd   = m_bus[132:128];
  assign m_we   = m_bus[133];
  assign m_re   = m_bus[134];
  assign m_sz   = m_bus[136:135];
  assign m_zext = m_bus[137];

  logic        e_ready, e_valid, e_allowin, e_pending, e_fwd;
  logic [63:0] e_result;
  assign e_ready   = !m_re || m_have || data_sram_rvalid;
  assign e_valid   = m_valid && e_ready;
  assign e_allowin = !m_valid || (e_ready && ws_allowin);
  assign e_pending = m_valid && m_re && !e_ready;
  assign e_fwd     = m_valid && m_we;
  assign e_result  = !m_re ? m_alu
                   : ext_ld(m_have ? m_data : data_sram_rdata, m_alu[2:0], m_sz, m_zext);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_have  <= 1'b0;
      m_data  <= 64'd0;
      m_bus   <= '0;
    end else begin
      if (m_valid && m_re && !m_have && data_sram_rvalid && !ws_allowin) begin
        m_have <= 1'b1;
        m_data <= data_sram_rdata;
      end
      if (e_allowin) begin
        m_valid <= es_to_ms_valid;
        m_have  <= 1'b0;
        if (es_to_ms_valid) m_bus <= es_to_ms_bus;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("m_to_ws_valid", ms_to_ws_valid, e_valid);
      chk("m_allowin", ms_allowin, e_allowin);
      chk("m_pending", ms_forward_bus[70], e_pending);
      chk("m_fwd_valid", ms_forward_bus[69], e_fwd);
      if (e_valid) begin
        chk("m_ws_bus", ms_to_ws_bus, {m_we, m_rd, e_result, m_pc});
        chk("m_fwd_data", ms_forward_bus[68:0], {e_result, m_rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_load(input string name, input logic [ESW-1:0] bus,
                         input logic [63:0] rd_data, input logic [63:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    tick();
    es_to_ms_valid   = 1'b0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = rd_data;
    settle();
    chk({name, "_valid"}, ms_to_ws_valid, 1'b1);
    chk({name, "_data"}, ms_forward_bus[68:5], exp);
    tick();
    data_sram_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_rdata = 64'd0; data_sram_rvalid = 1'b0;
    #12;
    chk("rst_valid", ms_to_ws_valid, 1'b0);
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_fwd_flags", ms_forward_bus[70:69], 2'b00);
    tick();
    reset = 1'b1;
    run   = 1'b1;

    // ALU pass-through
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 2'b11, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h8000_0000);
    tick();
    es_to_ms_valid = 1'b0;
    settle();
    chk("alu_valid", ms_to_ws_valid, 1'b1);
    chk("alu_fwd", ms_forward_bus, {1'b0, 1'b1, 64'h1234, 5'd5});
    tick();

    do_load("lb",  mk(1'b0, 2'b00, 1'b1, 1'b1, 5'd7, 64'h1003, 64'h8000_0004),
            64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    do_load("lbu", mk(1'b1, 2'b00, 1'b1, 1'b1, 5'd7, 64'h1003, 64'h8000_0008),
            64'h00000000_80000000, 64'h00000000_00000080);
    do_load("lw",  mk(1'b0, 2'b10, 1'b1, 1'b1, 5'd8, 64'h1004, 64'h8000_000c),
            64'h87654321_00000000, 64'hFFFFFFFF_87654321);
    do_load("ld",  mk(1'b0, 2'b11, 1'b1, 1'b1, 5'd8, 64'h1000, 64'h8000_0010),
            64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);

    // Three wait states on an lh
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 2'b01, 1'b1, 1'b1, 5'd10, 64'h1006, 64'h8000_0014);
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wait_pending", ms_forward_bus[70], 1'b1);
      chk("wait_allowin", ms_allowin, 1'b0);
      tick();
    end
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'hBEEF_0000_0000_0000;
    settle();
    chk("wait_data", ms_forward_bus[68:5], 64'hFFFFFFFF_FFFFBEEF);
    tick();
    data_sram_rvalid = 1'b0;

    // Write-back stall for 4 cycles with data changing after the first
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b1, 2'b10, 1'b1, 1'b1, 5'd11, 64'h1000, 64'h8000_0018);
    tick();
    es_to_ms_bus     = mk(1'b0, 2'b11, 1'b0, 1'b1, 5'd9, 64'hABC, 64'h8000_001c);
    ws_allowin       = 1'b0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'h11111111_F0000001;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stall_valid", ms_to_ws_valid, 1'b1);
      chk("stall_data", ms_to_ws_bus[127:64], 64'h00000000_F0000001);
      tick();
      data_sram_rdata  = 64'hDEAD_BEEF_DEAD_BEEF ^ 64'(i);
      data_sram_rvalid = i[0];
    end
    ws_allowin = 1'b1;
    settle();
    chk("stall_release", ms_to_ws_bus[127:64], 64'h00000000_F0000001);
    tick();
    es_to_ms_valid   = 1'b0;
    data_sram_rvalid = 1'b0;
    settle();
    chk("stall_next", ms_forward_bus[68:0], {64'hABC, 5'd9});
    tick();

    // Back-to-back load then addi
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 2'b11, 1'b1, 1'b1, 5'd3, 64'h2000, 64'h8000_0020);
    tick();
    es_to_ms_bus     = mk(1'b0, 2'b11, 1'b0, 1'b1, 5'd4, 64'h55, 64'h8000_0024);
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'hCAFE_F00D_1234_5678;
    settle();
    chk("b2b_load", ms_forward_bus[68:0], {64'hCAFE_F00D_1234_5678, 5'd3});
    chk("b2b_allowin", ms_allowin, 1'b1);
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    settle();
    chk("b2b_addi", ms_forward_bus, {1'b0, 1'b1, 64'h55, 5'd4});
    tick();
    data_sram_rvalid = 1'b0;

    // Reset in the middle of a wait
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 2'b11, 1'b1, 1'b1, 5'd12, 64'h3000, 64'h8000_0028);
    tick();
    es_to_ms_valid = 1'b0;
    settle();
    chk("rw_pending", ms_forward_bus[70], 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rw_valid", ms_to_ws_valid, 1'b0);
    chk("rw_allowin", ms_allowin, 1'b1);
    chk("rw_flags", ms_forward_bus[70:69], 2'b00);
    tick();
    reset            = 1'b1;
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'h7777_7777_7777_7777;
    settle();
    chk("rw_stray", ms_to_ws_valid, 1'b0);
    tick();
    data_sram_rvalid = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
